psg_wavetable_fetch_arbiter: RTL and testbench

- Shares one synchronous wave-table RAM port between the wave-table inputs (ack/wave) of NVOICE PSG tone generators and a CPU access port.
- Computes each voice's table address from its phase accumulator, base and size.
- Fetches only when that address changes or the table was written.
- Returns data per voice as a one-hot ack pulse plus a shared 12-bit wave bus.

---
 rtl/psg_wavetable_fetch_arbiter.sv | 169 ++++++++++++++++
 tb/tb_psg_wavetable_fetch_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_wavetable_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : psg_wavetable_fetch_arbiter
// Purpose  : Shares one synchronous wave-table RAM port between NVOICE PSG
//            tone-generator voices and a CPU access port. Each voice's table
//            address is derived from its phase accumulator, base and log2
//            size; a voice is fetched only when that address changes or the
//            table has been written since its last fetch.
// Ports    : clk, rst (async, active-low)
//            acc_i / wt_en_i / wt_base_i / wt_len_i : per-voice table setup
//            voice_ack_o / wave_o                   : per-voice data return
//            cpu_req_i / cpu_we_i / cpu_adr_i / cpu_dat_i,
//            cpu_gnt_o / cpu_ack_o / cpu_dat_o      : CPU access port
//            ram_ce_o / ram_we_o / ram_adr_o / ram_wdat_o / ram_rdat_i : RAM
// Revision : 1.0 - initial release
// ============================================================================
module psg_wavetable_fetch_arbiter #(
  parameter int NVOICE = 4,
  parameter int AW     = 14,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NVOICE*32-1:0] acc_i,
  input  logic [NVOICE-1:0]    wt_en_i,
  input  logic [NVOICE*AW-1:0] wt_base_i,
  input  logic [NVOICE*4-1:0]  wt_len_i,
  output logic [NVOICE-1:0]    voice_ack_o,
  output logic [11:0]          wave_o,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [AW-1:0]        cpu_adr_i,
  input  logic [11:0]          cpu_dat_i,
  output logic                 cpu_gnt_o,
  output logic                 cpu_ack_o,
  output logic [11:0]          cpu_dat_o,
  output logic                 ram_ce_o,
  output logic                 ram_we_o,
  output logic [AW-1:0]        ram_adr_o,
  output logic [11:0]          ram_wdat_o,
  input  logic [11:0]          ram_rdat_i
);

  localparam int VW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  // tag = {valid, is_cpu, is_write, voice}
  localparam int TW = VW + 3;

  logic [NVOICE-1:0][AW-1:0] w_addr;
  logic [NVOICE-1:0][AW-1:0] r_last_adr;
  logic [NVOICE-1:0]         r_stale;
  logic [NVOICE-1:0]         w_pend;
  logic [VW-1:0]             r_rr;
  logic [1:0]                r_starve;
  logic [RD_LAT:0][TW-1:0]   r_tag;

  logic          w_any_pend;
  logic          w_vfound;
  logic [VW-1:0] w_vsel;
  logic [VW-1:0] w_cand;
  logic          w_block;
  logic          w_gnt_cpu;
  logic          w_gnt_voice;
  logic [TW-1:0] w_tag_new;
  logic [TW-1:0] w_ret;
  logic          w_unused_acc;

  // Only acc[27:16] of each voice addresses the table; the rest is phase
  // fraction owned by the tone generator.
  assign w_unused_acc = ^acc_i;

  // Per-voice table address: top L bits of the 12-bit phase index, offset
  // by the table base, wrapping silently in the AW-bit address space.
  generate
    for (genvar v = 0; v < NVOICE; v++) begin : g_addr
      logic [3:0]  w_len;
      logic [11:0] w_idx;
      assign w_len     = (wt_len_i[4*v +: 4] > 4'd12) ? 4'd12 : wt_len_i[4*v +: 4];
      assign w_idx     = acc_i[32*v+16 +: 12] >> (4'd12 - w_len);
      assign w_addr[v] = wt_base_i[AW*v +: AW] + AW'(w_idx);
      assign w_pend[v] = wt_en_i[v] & (r_stale[v] | (w_addr[v] != r_last_adr[v]));
    end
  endgenerate

  // Arbitration: CPU first unless voices have been starved three grants in
  // a row; voices served round-robin starting just after the last winner.
  always_comb begin
    w_any_pend = |w_pend;
    w_vfound   = 1'b0;
    w_vsel     = r_rr;
    w_cand     = r_rr;
    for (int k = 1; k <= NVOICE; k++) begin
      w_cand = VW'((int'(r_rr) + k) % NVOICE);
      if (!w_vfound && w_pend[w_cand]) begin
        w_vfound = 1'b1;
        w_vsel   = w_cand;
      end
    end
    w_block     = (r_starve == 2'd3) & w_any_pend;
    // Gated by rst so the combinational grant also reads 0 during reset.
    w_gnt_cpu   = rst & cpu_req_i & ~w_block;
    w_gnt_voice = rst & ~w_gnt_cpu & w_vfound;
    w_tag_new   = {w_gnt_cpu | w_gnt_voice, w_gnt_cpu, w_gnt_cpu & cpu_we_i,
                   w_gnt_cpu ? {VW{1'b0}} : w_vsel};
  end

  assign cpu_gnt_o = w_gnt_cpu;
  assign w_ret     = r_tag[RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_adr_o   <= '0;
      ram_wdat_o  <= '0;
      voice_ack_o <= '0;
      wave_o      <= '0;
      cpu_ack_o   <= 1'b0;
      cpu_dat_o   <= '0;
      r_stale     <= '1;
      r_last_adr  <= '0;
      r_rr        <= VW'(NVOICE - 1);
      r_starve    <= 2'd0;
      r_tag       <= '0;
    end else begin
      // RAM command, valid the cycle after the grant
      ram_ce_o <= w_gnt_cpu | w_gnt_voice;
      ram_we_o <= w_gnt_cpu & cpu_we_i;
      if (w_gnt_cpu) begin
        ram_adr_o <= cpu_adr_i;
        if (cpu_we_i) ram_wdat_o <= cpu_dat_i;
      end else if (w_gnt_voice) begin
        ram_adr_o <= w_addr[w_vsel];
      end

      // A table write invalidates every voice's cached sample, including
      // fetches already in flight that will return pre-write data.
      if (w_gnt_cpu && cpu_we_i) begin
        r_stale <= '1;
      end else if (w_gnt_voice) begin
        r_stale[w_vsel]    <= 1'b0;
        r_last_adr[w_vsel] <= w_addr[w_vsel];
        r_rr               <= w_vsel;
      end

      if (w_gnt_voice || !w_any_pend)
        r_starve <= 2'd0;
      else if (w_gnt_cpu && r_starve != 2'd3)
        r_starve <= r_starve + 2'd1;

      // Tag travels alongside the RAM access so the return can be routed.
      r_tag[0] <= w_tag_new;
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];

      voice_ack_o <= '0;
      cpu_ack_o   <= 1'b0;
      if (w_ret[TW-1]) begin
        if (w_ret[TW-2]) begin
          cpu_ack_o <= 1'b1;
          if (!w_ret[TW-3]) cpu_dat_o <= ram_rdat_i;
        end else begin
          voice_ack_o[w_ret[VW-1:0]] <= 1'b1;
          wave_o                     <= ram_rdat_i;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psg_wavetable_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_psg_wavetable_fetch_arbiter
// Purpose  : Directed self-checking bench for psg_wavetable_fetch_arbiter
//            (NVOICE=4, AW=14, RD_LAT=1) with a behavioural synchronous RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psg_wavetable_fetch_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] acc;
  logic [3:0]   wt_en;
  logic [55:0]  wt_base;
  logic [15:0]  wt_len;
  logic [3:0]   voice_ack;
  logic [11:0]  wave;
  logic         cpu_req, cpu_we, cpu_gnt, cpu_ack;
  logic [13:0]  cpu_adr;
  logic [11:0]  cpu_wdat, cpu_rdat;
  logic         ram_ce, ram_we;
  logic [13:0]  ram_adr;
  logic [11:0]  ram_wdat, ram_rdat;

  int n_total = 0;
  int n_bad   = 0;
  int n_ack;
  int n_ce;
  logic [13:0] exp_adr [4];
  logic        exp_gnt [5];

  always #5 clk = ~clk;

  psg_wavetable_fetch_arbiter #(.NVOICE(4), .AW(14), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .acc_i(acc), .wt_en_i(wt_en), .wt_base_i(wt_base), .wt_len_i(wt_len),
    .voice_ack_o(voice_ack), .wave_o(wave),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_wdat),
    .cpu_gnt_o(cpu_gnt), .cpu_ack_o(cpu_ack), .cpu_dat_o(cpu_rdat),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_adr_o(ram_adr),
    .ram_wdat_o(ram_wdat), .ram_rdat_i(ram_rdat)
  );

  // Synchronous RAM, one cycle read latency, preloaded with a known pattern.
  logic [11:0] mem [0:16383];

  function automatic logic [11:0] init_val(input int a);
    return 12'((a * 37 + 5) & 32'hFFF);
  endfunction

  initial for (int i = 0; i < 16384; i++) mem[i] = init_val(i);

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_adr] = ram_wdat;
      else        ram_rdat <= mem[ram_adr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_voice(input int v, input logic [13:0] base,
                           input logic [3:0] len, input logic [11:0] idx);
    acc[32*v +: 32]     = {4'h0, idx, 16'h0};
    wt_base[14*v +: 14] = base;
    wt_len[4*v +: 4]    = len;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    cpu_req = 1'b0;
    wt_en   = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = '0; cpu_wdat = '0;
    acc = '0; wt_en = '0; wt_base = '0; wt_len = '0;
    step();
    step();
    // ---- reset state (CPU requesting, yet no grant) ----
    check("rst_ce",   ram_ce, 0);
    check("rst_we",   ram_we, 0);
    check("rst_adr",  ram_adr, 0);
    check("rst_vack", voice_ack, 0);
    check("rst_wave", wave, 0);
    check("rst_cack", cpu_ack, 0);
    check("rst_gnt",  cpu_gnt, 0);

    // ---- T1: single voice fetch, latency and no refetch ----
    step();
    rst = 1'b1; cpu_req = 1'b0;
    set_voice(0, 14'h100, 4'd8, 12'hAB0);
    wt_en = 4'b0001;
    step();
    check("t1_ce",  ram_ce, 1);
    check("t1_we",  ram_we, 0);
    check("t1_adr", ram_adr, 14'h1AB);
    step();
    check("t1_ack_early", voice_ack, 0);
    step();
    check("t1_ack",  voice_ack, 4'b0001);
    check("t1_wave", wave, init_val(14'h1AB));
    n_ce = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (ram_ce) n_ce++;
    end
    check("t1_norefetch", n_ce, 0);

    // ---- T2: four voices pending together, served 0..3 ----
    do_reset();
    set_voice(0, 14'h200, 4'd8,  12'hAB0);
    set_voice(1, 14'h300, 4'd8,  12'h120);
    set_voice(2, 14'h400, 4'd4,  12'hF00);
    set_voice(3, 14'h500, 4'd12, 12'h123);
    wt_en = 4'b1111;
    exp_adr = '{14'h2AB, 14'h312, 14'h40F, 14'h623};
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k <= 4) begin
        check("t2_ce",  ram_ce, 1);
        check("t2_adr", ram_adr, exp_adr[k-1]);
      end else begin
        check("t2_idle", ram_ce, 0);
      end
      if (k >= 3 && k <= 6) begin
        check("t2_ack",  voice_ack, 32'(1) << (k - 3));
        check("t2_wave", wave, init_val(exp_adr[k-3]));
      end else begin
        check("t2_noack", voice_ack, 0);
      end
    end

    // ---- T3: CPU held high vs pending voice 2 (starvation limit) ----
    set_voice(2, 14'h400, 4'd4, 12'hE00);
    cpu_we  = 1'b0;
    cpu_adr = 14'h040;
    exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    n_ack   = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      cpu_req = (k < 5);
      if (cpu_ack) n_ack++;
      #1;
      if (k < 5) check("t3_gnt", cpu_gnt, exp_gnt[k]);
      if (k == 3) begin
        check("t3_cack", cpu_ack, 1);
        check("t3_rdat", cpu_rdat, init_val(14'h040));
      end
      if (k == 4) check("t3_vadr", ram_adr, 14'h40E);
      if (k == 6) begin
        check("t3_vack",  voice_ack, 4'b0100);
        check("t3_vwave", wave, init_val(14'h40E));
      end
    end
    check("t3_ackcnt", n_ack, 4);

    // ---- T4: CPU write invalidates voice 0 and it refetches ----
    set_voice(0, 14'h100, 4'd8, 12'hAB0);
    wt_en = 4'b0001;
    for (int k = 0; k < 6; k++) step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 14'h1AB; cpu_wdat = 12'h5A5;
    #1;
    check("t4_gnt", cpu_gnt, 1);
    step();
    cpu_req = 1'b0;
    check("t4_wce",   ram_ce, 1);
    check("t4_wwe",   ram_we, 1);
    check("t4_wadr",  ram_adr, 14'h1AB);
    check("t4_wdat",  ram_wdat, 12'h5A5);
    step();
    check("t4_rce",   ram_ce, 1);
    check("t4_rwe",   ram_we, 0);
    check("t4_radr",  ram_adr, 14'h1AB);
    step();
    check("t4_cack",  cpu_ack, 1);
    check("t4_chold", cpu_rdat, init_val(14'h040));
    step();
    check("t4_vack",  voice_ack, 4'b0001);
    check("t4_wave",  wave, 12'h5A5);

    // ---- T5: address wrap and length clamp ----
    set_voice(0, 14'h3FFF, 4'd4, 12'h300);
    step();
    check("t5_wrap", ram_adr, 14'h0002);
    step();
    step();
    check("t5_wack",  voice_ack, 4'b0001);
    check("t5_wwave", wave, init_val(2));
    set_voice(0, 14'h0000, 4'd15, 12'h123);
    step();
    check("t5_clamp_ce",  ram_ce, 1);
    check("t5_clamp_adr", ram_adr, 14'h123);
    for (int k = 0; k < 4; k++) step();

    // ---- T6: reset while two reads are in flight ----
    set_voice(1, 14'h300, 4'd8, 12'h130);
    set_voice(2, 14'h400, 4'd4, 12'hD00);
    wt_en = 4'b0110;
    step();
    check("t6_adr1", ram_adr, 14'h313);
    step();
    rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0;
    #1;
    check("t6_ce",   ram_ce, 0);
    check("t6_we",   ram_we, 0);
    check("t6_adr",  ram_adr, 0);
    check("t6_wdat", ram_wdat, 0);
    check("t6_vack", voice_ack, 0);
    check("t6_wave", wave, 0);
    check("t6_cack", cpu_ack, 0);
    check("t6_cdat", cpu_rdat, 0);
    check("t6_gnt",  cpu_gnt, 0);
    step();
    check("t6_hold_vack", voice_ack, 0);
    step();
    rst = 1'b1; cpu_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      if (k <= 2) begin
        check("t6_post_vack", voice_ack, 0);
        check("t6_post_cack", cpu_ack, 0);
      end
      if (k == 1) check("t6_re_adr1", ram_adr, 14'h313);
      if (k == 2) check("t6_re_adr2", ram_adr, 14'h40D);
      if (k == 3) begin
        check("t6_re_ack1",  voice_ack, 4'b0010);
        check("t6_re_wave1", wave, init_val(14'h313));
      end
      if (k == 4) check("t6_re_ack2", voice_ack, 4'b0100);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
